// File: rtl/sdiv_seq.sv
// Sequential signed fixed-point divider: out = in1 / in2, one restoring step
// per clock, saturating on range overflow and flagging a zero divisor.
module sdiv_seq #(
    parameter int WI1 = 5,
    parameter int WF1 = 4,
    parameter int WI2 = 7,
    parameter int WF2 = 3,
    parameter int WIO = 12,
    parameter int WFO = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WI1+WF1-1:0]   in1,
    input  logic [WI2+WF2-1:0]   in2,
    output logic                 busy,
    output logic                 done,
    output logic [WIO+WFO-1:0]   out,
    output logic                 ovf,
    output logic                 dz
);

    localparam int W1 = WI1 + WF1;
    localparam int W2 = WI2 + WF2;
    localparam int N  = WIO + WFO;
    localparam int S  = WFO + WF2 - WF1;
    localparam int RW = W1 + S + W2 + N;
    localparam int CW = $clog2(N + 1);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DIV   = 2'd2,
        ST_FIX   = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [W1-1:0]   a_r;
    logic [W2-1:0]   b_r;
    logic [RW-1:0]   rem_r, dvs_r, rem_nxt_s, dvd_s;
    logic [N-1:0]    q_r;
    logic [CW-1:0]   cnt_r;
    logic            dzf_r, povf_r;
    logic [W1-1:0]   a_mag_s;
    logic [W2-1:0]   b_mag_s;
    logic            ge_s, pre_ovf_s, neg_s, ovf_cond_s;
    logic [N-1:0]    res_s;
    logic            res_ovf_s, busy_nxt_s, done_nxt_s;
    logic [N-1:0]    out_r;
    logic            ovf_r, dz_r, busy_r, done_r;

    // Magnitudes are kept at full width so the most-negative code maps to 2^(W-1).
    function automatic logic [W1-1:0] mag1(input logic [W1-1:0] v);
        mag1 = v[W1-1] ? (~v + W1'(1'b1)) : v;
    endfunction

    function automatic logic [W2-1:0] mag2(input logic [W2-1:0] v);
        mag2 = v[W2-1] ? (~v + W2'(1'b1)) : v;
    endfunction

    // Operand magnitudes, pre-overflow test and one restoring step.
    always_comb begin
        a_mag_s   = mag1(a_r);
        b_mag_s   = mag2(b_r);
        dvd_s     = RW'(a_mag_s) << S;
        pre_ovf_s = (dvd_s >= (RW'(b_mag_s) << N));
        neg_s     = a_r[W1-1] ^ b_r[W2-1];
        ge_s      = (rem_r >= dvs_r);
        if (ge_s) begin
            rem_nxt_s = rem_r - dvs_r;
        end else begin
            rem_nxt_s = rem_r;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: state_nxt_s = ST_DIV;
            ST_DIV: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: handshake next values and result selection for the FIX cycle.
    always_comb begin
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_r == ST_FIX);
        ovf_cond_s = povf_r | (neg_s ? (q_r > MIN_NEG) : q_r[N-1]);
        res_s      = q_r;
        res_ovf_s  = 1'b0;
        if (dzf_r) begin
            res_s     = a_r[W1-1] ? MIN_NEG : MAX_POS;
            res_ovf_s = 1'b0;
        end else if (ovf_cond_s) begin
            res_s     = neg_s ? MIN_NEG : MAX_POS;
            res_ovf_s = 1'b1;
        end else begin
            res_s     = neg_s ? (~q_r + N'(1'b1)) : q_r;
            res_ovf_s = 1'b0;
        end
    end

    // Datapath and registered outputs; results only change on leaving FIX.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_r    <= {W1{1'b0}};
            b_r    <= {W2{1'b0}};
            rem_r  <= {RW{1'b0}};
            dvs_r  <= {RW{1'b0}};
            q_r    <= {N{1'b0}};
            cnt_r  <= {CW{1'b0}};
            dzf_r  <= 1'b0;
            povf_r <= 1'b0;
            out_r  <= {N{1'b0}};
            ovf_r  <= 1'b0;
            dz_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r <= in1;
                        b_r <= in2;
                    end
                end
                ST_CHECK: begin
                    rem_r  <= dvd_s;
                    dvs_r  <= RW'(b_mag_s) << (N - 1);
                    q_r    <= {N{1'b0}};
                    cnt_r  <= CW'(N - 1);
                    dzf_r  <= (b_r == {W2{1'b0}});
                    povf_r <= pre_ovf_s;
                end
                ST_DIV: begin
                    rem_r <= rem_nxt_s;
                    dvs_r <= dvs_r >> 1;
                    q_r   <= {q_r[N-2:0], ge_s};
                    cnt_r <= cnt_r - CW'(1'b1);
                end
                ST_FIX: begin
                    out_r <= res_s;
                    ovf_r <= res_ovf_s;
                    dz_r  <= dzf_r;
                end
                default: begin
                    out_r <= out_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign out  = out_r;
    assign ovf  = ovf_r;
    assign dz   = dz_r;

endmodule
